// File: rtl/fpnew_req_sched.sv
// fpnew_req_sched: round-robin scheduler that shares one FPU between NumReq
// requesters, tracks per-requester in-flight counts and routes results back
// by the requester id carried in the FPU tag.
// Optional macro FPNEW_REQ_SCHED_RSP_REG_EN inserts a one-entry response spill
// register (1-cycle response latency); without it the response path is combinational.
module fpnew_req_sched #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned PayloadWidth   = 256,
  parameter int unsigned Width          = 64,
  parameter int unsigned UserTagWidth   = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic [NumReq-1:0]                             req_valid_i,
  output logic [NumReq-1:0]                             req_ready_o,
  input  logic [NumReq-1:0][PayloadWidth-1:0]           req_payload_i,
  input  logic [NumReq-1:0][UserTagWidth-1:0]           req_tag_i,
  output logic [NumReq-1:0]                             rsp_valid_o,
  input  logic [NumReq-1:0]                             rsp_ready_i,
  output logic [Width-1:0]                              rsp_result_o,
  output logic [4:0]                                    rsp_status_o,
  output logic [UserTagWidth-1:0]                       rsp_tag_o,
  output logic                                          fpu_in_valid_o,
  input  logic                                          fpu_in_ready_i,
  output logic [PayloadWidth-1:0]                       fpu_payload_o,
  output logic [$clog2(NumReq)+UserTagWidth-1:0]        fpu_tag_o,
  input  logic                                          fpu_out_valid_i,
  output logic                                          fpu_out_ready_o,
  input  logic [Width-1:0]                              fpu_result_i,
  input  logic [4:0]                                    fpu_status_i,
  input  logic [$clog2(NumReq)+UserTagWidth-1:0]        fpu_tag_i,
  output logic                                          fpu_flush_o,
  output logic                                          busy_o
);

  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned TagW = IdW + UserTagWidth;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                       state_q, state_d;
  logic [IdW-1:0]                   grant_q, grant_d;
  logic [IdW-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [NumReq-1:0][CntW-1:0]      cnt_q;
  logic [NumReq-1:0]                eligible;
  logic [NumReq-1:0]                cnt_inc, cnt_dec;
  logic                             arb_found;
  logic [IdW-1:0]                   arb_idx;
  int unsigned                      cand;
  logic [IdW-1:0]                   grant;
  logic                             live;
  logic                             issue_hs;
  logic [IdW-1:0]                   out_id;
  logic                             out_valid;
  logic                             rsp_hs;
  logic                             rsp_full;

  // Outputs are quiet while in reset or while a flush is being applied
  assign live        = rst_ni & ~flush_i;
  assign fpu_flush_o = flush_i;

  // Eligibility: valid and below the per-requester in-flight limit
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < CntW'(MaxOutstanding));
    end
  end

  // Round-robin search starting at rr_ptr
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(rr_ptr_q) + k) % NumReq;
      if (!arb_found && eligible[IdW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IdW'(cand);
      end
    end
  end

  // Issue side: latched grant while holding, arbitration winner otherwise
  assign grant          = (state_q == HOLD) ? grant_q : arb_idx;
  assign fpu_in_valid_o = live & ((state_q == HOLD) | arb_found);
  assign issue_hs       = fpu_in_valid_o & fpu_in_ready_i;
  assign req_ready_o    = issue_hs ? (NumReq'(1) << grant) : '0;
  assign fpu_payload_o  = req_payload_i[grant];
  assign fpu_tag_o      = {grant, req_tag_i[grant]};

  // Next-state logic for the IDLE/HOLD issue FSM and round-robin pointer
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      state_d  = IDLE;
      rr_ptr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fpu_in_valid_o && !fpu_in_ready_i) begin
            state_d = HOLD;
            grant_d = arb_idx;
          end
        end
        HOLD: begin
          if (fpu_in_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (issue_hs) begin
        rr_ptr_d = (grant == IdW'(NumReq - 1)) ? '0 : grant + IdW'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef FPNEW_REQ_SCHED_RSP_REG_EN
  logic                 rsp_full_q;
  logic [Width-1:0]     rsp_result_q;
  logic [4:0]           rsp_status_q;
  logic [TagW-1:0]      rsp_tag_q;

  assign out_id          = rsp_tag_q[TagW-1 -: IdW];
  assign out_valid       = rsp_full_q;
  assign rsp_full        = rsp_full_q;
  assign rsp_result_o    = rsp_result_q;
  assign rsp_status_o    = rsp_status_q;
  assign rsp_tag_o       = rsp_tag_q[UserTagWidth-1:0];
  // Accept when empty or when the held entry leaves this cycle (no bubble)
  assign fpu_out_ready_o = live & (~rsp_full_q | rsp_ready_i[out_id]);

  // One-entry response spill register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_full_q   <= 1'b0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
      rsp_tag_q    <= '0;
    end else if (flush_i) begin
      rsp_full_q   <= 1'b0;
    end else if (fpu_out_valid_i && fpu_out_ready_o) begin
      rsp_full_q   <= 1'b1;
      rsp_result_q <= fpu_result_i;
      rsp_status_q <= fpu_status_i;
      rsp_tag_q    <= fpu_tag_i;
    end else if (rsp_hs) begin
      rsp_full_q   <= 1'b0;
    end
  end
`else
  assign out_id          = fpu_tag_i[TagW-1 -: IdW];
  assign out_valid       = fpu_out_valid_i;
  assign rsp_full        = 1'b0;
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;
  assign rsp_tag_o       = fpu_tag_i[UserTagWidth-1:0];
  assign fpu_out_ready_o = live & rsp_ready_i[out_id];
`endif

  // Route the response to the requester named by the tag MSBs
  assign rsp_valid_o = (live & out_valid) ? (NumReq'(1) << out_id) : '0;
  assign rsp_hs      = live & out_valid & rsp_ready_i[out_id];

  // Per-requester issue/response events
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cnt_inc[i] = issue_hs && (grant == IdW'(i));
      cnt_dec[i] = rsp_hs && (out_id == IdW'(i));
    end
  end

  // Saturating in-flight counters; simultaneous issue and response cancel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (cnt_inc[i] && !cnt_dec[i] && (cnt_q[i] < CntW'(MaxOutstanding))) begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end else if (cnt_dec[i] && !cnt_inc[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - CntW'(1);
        end
      end
    end
  end

  assign busy_o = (|cnt_q) | (state_q == HOLD) | rsp_full;

  // A response for a requester with nothing in flight is a protocol error
  a_rsp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_hs |-> (cnt_q[out_id] != '0));

endmodule

// File: tb/tb_fpnew_req_sched.sv
// Directed bench for fpnew_req_sched with issue/response scoreboards.
module tb_fpnew_req_sched;

  localparam int unsigned NumReq = 2;
  localparam int unsigned PW     = 256;
  localparam int unsigned W      = 64;
  localparam int unsigned UTW    = 4;
  localparam int unsigned TagW   = 5;
`ifdef FPNEW_REQ_SCHED_RSP_REG_EN
  localparam int RspLat = 1;
`else
  localparam int RspLat = 0;
`endif

  logic                        clk_i;
  logic                        rst_ni;
  logic                        flush_i;
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq-1:0][PW-1:0]   req_payload_i;
  logic [NumReq-1:0][UTW-1:0]  req_tag_i;
  logic [NumReq-1:0]           rsp_valid_o;
  logic [NumReq-1:0]           rsp_ready_i;
  logic [W-1:0]                rsp_result_o;
  logic [4:0]                  rsp_status_o;
  logic [UTW-1:0]              rsp_tag_o;
  logic                        fpu_in_valid_o;
  logic                        fpu_in_ready_i;
  logic [PW-1:0]               fpu_payload_o;
  logic [TagW-1:0]             fpu_tag_o;
  logic                        fpu_out_valid_i;
  logic                        fpu_out_ready_o;
  logic [W-1:0]                fpu_result_i;
  logic [4:0]                  fpu_status_i;
  logic [TagW-1:0]             fpu_tag_i;
  logic                        fpu_flush_o;
  logic                        busy_o;

  fpnew_req_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_payload_i(req_payload_i), .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_payload_o(fpu_payload_o), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .fpu_flush_o(fpu_flush_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [TagW-1:0] tag;
    logic [PW-1:0]   payload;
  } iss_t;

  typedef struct {
    logic [NumReq-1:0] valid;
    logic [W-1:0]      result;
    logic [4:0]        status;
    logic [UTW-1:0]    tag;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t ie;
  rsp_t re;
  int   n_chk;
  int   n_fail;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_iss(input logic id, input logic [UTW-1:0] utag, input logic [PW-1:0] pl);
    iss_q.push_back('{tag: {id, utag}, payload: pl});
  endtask

  task automatic push_rsp(input logic id, input logic [UTW-1:0] utag, input logic [W-1:0] res,
                          input logic [4:0] st);
    rsp_q.push_back('{valid: (NumReq'(1) << id), result: res, status: st, tag: utag});
  endtask

  // Issue scoreboard: every FPU-side handshake must match the next expected issue
  always @(negedge clk_i) begin
    if (rst_ni && fpu_in_valid_o && fpu_in_ready_i) begin
      if (iss_q.size() == 0) begin
        check("issue_unexpected", PW'(fpu_tag_o), PW'({TagW{1'bx}}));
      end else begin
        ie = iss_q.pop_front();
        check("issue_tag", PW'(fpu_tag_o), PW'(ie.tag));
        check("issue_payload", fpu_payload_o, ie.payload);
      end
    end
  end

  // Response scoreboard: every requester-side handshake must match the next expected response
  always @(negedge clk_i) begin
    if (rst_ni && |(rsp_valid_o & rsp_ready_i)) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", PW'(rsp_valid_o), PW'(0));
      end else begin
        re = rsp_q.pop_front();
        check("rsp_valid", PW'(rsp_valid_o), PW'(re.valid));
        check("rsp_result", PW'(rsp_result_o), PW'(re.result));
        check("rsp_status", PW'(rsp_status_o), PW'(re.status));
        check("rsp_tag", PW'(rsp_tag_o), PW'(re.tag));
      end
    end
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_ni = 1'b0;
    flush_i = 1'b0;
    req_valid_i = 2'b11;
    req_payload_i = '0;
    req_tag_i = '0;
    rsp_ready_i = '0;
    fpu_in_ready_i = 1'b1;
    fpu_out_valid_i = 1'b1;
    fpu_result_i = '0;
    fpu_status_i = '0;
    fpu_tag_i = '0;

    // Outputs quiet during reset even with live inputs
    #12;
    check("rst_in_valid", PW'(fpu_in_valid_o), PW'(0));
    check("rst_req_ready", PW'(req_ready_o), PW'(0));
    check("rst_rsp_valid", PW'(rsp_valid_o), PW'(0));
    check("rst_busy", PW'(busy_o), PW'(0));
    req_valid_i = '0;
    fpu_out_valid_i = 1'b0;
    fpu_in_ready_i = 1'b0;
    rst_ni = 1'b1;
    tick();
    #1;
    check("idle_in_valid", PW'(fpu_in_valid_o), PW'(0));
    check("idle_req_ready", PW'(req_ready_o), PW'(0));
    check("idle_rsp_valid", PW'(rsp_valid_o), PW'(0));
    check("idle_out_ready", PW'(fpu_out_ready_o), PW'(0));
    check("idle_busy", PW'(busy_o), PW'(0));
    check("idle_flush", PW'(fpu_flush_o), PW'(0));
    tick();

    // Both requesting continuously: grants alternate 0,1,0,1
    req_payload_i[0] = PW'(32'hA0);
    req_payload_i[1] = PW'(32'hA1);
    req_tag_i[0] = 4'h5;
    req_tag_i[1] = 4'h9;
    req_valid_i = 2'b11;
    fpu_in_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_iss(1'b0, 4'h5, PW'(32'hA0));
      else            push_iss(1'b1, 4'h9, PW'(32'hA1));
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_tag_msb", PW'(fpu_tag_o[TagW-1]), PW'(k % 2));
      check("rr_req_ready", PW'(req_ready_o), PW'(2'b01 << (k % 2)));
      tick();
    end
    req_valid_i = '0;
    #1;
    check("rr_busy", PW'(busy_o), PW'(1));
    check("rr_in_valid_off", PW'(fpu_in_valid_o), PW'(0));
    tick();

    // Stall: requester 0 held 3 cycles, requester 1 joins in cycle 2
    req_payload_i[0] = PW'(32'hB0);
    req_valid_i = 2'b01;
    fpu_in_ready_i = 1'b0;
    #1;
    check("hold_c1_valid", PW'(fpu_in_valid_o), PW'(1));
    check("hold_c1_payload", fpu_payload_o, PW'(32'hB0));
    check("hold_c1_tag", PW'(fpu_tag_o), PW'(5'h05));
    check("hold_c1_ready", PW'(req_ready_o), PW'(0));
    tick();
    req_valid_i = 2'b11;
    #1;
    check("hold_c2_payload", fpu_payload_o, PW'(32'hB0));
    check("hold_c2_tag", PW'(fpu_tag_o), PW'(5'h05));
    check("hold_c2_ready", PW'(req_ready_o), PW'(0));
    check("hold_c2_busy", PW'(busy_o), PW'(1));
    tick();
    #1;
    check("hold_c3_payload", fpu_payload_o, PW'(32'hB0));
    check("hold_c3_valid", PW'(fpu_in_valid_o), PW'(1));
    tick();
    push_iss(1'b0, 4'h5, PW'(32'hB0));
    fpu_in_ready_i = 1'b1;
    #1;
    check("hold_release_ready", PW'(req_ready_o), PW'(2'b01));
    tick();
    req_valid_i = 2'b10;
    push_iss(1'b1, 4'h9, PW'(32'hA1));
    #1;
    check("hold_next_ready", PW'(req_ready_o), PW'(2'b10));
    tick();

    // Outstanding limit on requester 0 (3 in flight -> 4 -> blocked)
    req_valid_i = 2'b01;
    push_iss(1'b0, 4'h5, PW'(32'hB0));
    #1;
    check("max_4th_ready", PW'(req_ready_o), PW'(2'b01));
    tick();
    #1;
    check("max_5th_ready", PW'(req_ready_o), PW'(0));
    check("max_5th_valid", PW'(fpu_in_valid_o), PW'(0));
    tick();
    #1;
    check("max_5th_valid_b", PW'(fpu_in_valid_o), PW'(0));
    fpu_out_valid_i = 1'b1;
    fpu_tag_i = {1'b0, 4'h5};
    fpu_result_i = 64'h1111;
    fpu_status_i = 5'h01;
    rsp_ready_i = 2'b01;
    push_rsp(1'b0, 4'h5, 64'h1111, 5'h01);
    #1;
    check("max_rsp_out_ready", PW'(fpu_out_ready_o), PW'(1));
    check("max_rsp_req_ready", PW'(req_ready_o), PW'(0));
    tick();
    fpu_out_valid_i = 1'b0;
    repeat (RspLat) tick();
    push_iss(1'b0, 4'h5, PW'(32'hB0));
    #1;
    check("max_after_rsp_ready", PW'(req_ready_o), PW'(2'b01));
    tick();

    // Response backpressure for requester 1
    req_valid_i = '0;
    fpu_out_valid_i = 1'b1;
    fpu_tag_i = {1'b1, 4'h9};
    fpu_result_i = 64'h2222_3333;
    fpu_status_i = 5'h15;
    rsp_ready_i = 2'b00;
    push_rsp(1'b1, 4'h9, 64'h2222_3333, 5'h15);
`ifdef FPNEW_REQ_SCHED_RSP_REG_EN
    #1;
    check("bp_load_ready", PW'(fpu_out_ready_o), PW'(1));
    check("bp_latency", PW'(rsp_valid_o), PW'(0));
    tick();
    fpu_out_valid_i = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      #1;
      check("bp_out_ready", PW'(fpu_out_ready_o), PW'(0));
      check("bp_rsp_valid", PW'(rsp_valid_o), PW'(2'b10));
      check("bp_result", PW'(rsp_result_o), PW'(64'h2222_3333));
      tick();
    end
    rsp_ready_i = 2'b10;
    #1;
    check("bp_release_ready", PW'(fpu_out_ready_o), PW'(1));
    tick();

    // Back-to-back responses at full throughput
    rsp_ready_i = 2'b11;
    fpu_out_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fpu_tag_i = (k == 2) ? {1'b1, 4'h9} : {1'b0, 4'h5};
      fpu_result_i = W'(16 + k);
      fpu_status_i = 5'(k);
      push_rsp(k == 2, (k == 2) ? 4'h9 : 4'h5, W'(16 + k), 5'(k));
      #1;
      check("b2b_out_ready", PW'(fpu_out_ready_o), PW'(1));
      tick();
    end
    fpu_out_valid_i = 1'b0;
    tick();
    tick();
    #1;
    check("b2b_busy", PW'(busy_o), PW'(1));
    tick();

    // Flush with 3 in flight and a HOLD pending
    req_valid_i = 2'b10;
    fpu_in_ready_i = 1'b0;
    #1;
    check("fl_hold_valid", PW'(fpu_in_valid_o), PW'(1));
    check("fl_hold_id", PW'(fpu_tag_o[TagW-1]), PW'(1));
    tick();
    flush_i = 1'b1;
    fpu_out_valid_i = 1'b1;
    fpu_tag_i = {1'b0, 4'h5};
    #1;
    check("fl_in_valid", PW'(fpu_in_valid_o), PW'(0));
    check("fl_req_ready", PW'(req_ready_o), PW'(0));
    check("fl_rsp_valid", PW'(rsp_valid_o), PW'(0));
    check("fl_fwd", PW'(fpu_flush_o), PW'(1));
    tick();
    flush_i = 1'b0;
    fpu_out_valid_i = 1'b0;
    req_valid_i = '0;
    fpu_in_ready_i = 1'b1;
    #1;
    check("fl_busy", PW'(busy_o), PW'(0));
    check("fl_in_valid_after", PW'(fpu_in_valid_o), PW'(0));
    tick();
    req_valid_i = 2'b11;
    push_iss(1'b0, 4'h5, PW'(32'hB0));
    #1;
    check("fl_rr_reset", PW'(fpu_tag_o[TagW-1]), PW'(0));
    check("fl_req_ready_after", PW'(req_ready_o), PW'(2'b01));
    tick();

    // Reset asserted mid-HOLD drops the held request
    req_valid_i = 2'b10;
    fpu_in_ready_i = 1'b0;
    tick();
    #1;
    check("rh_busy", PW'(busy_o), PW'(1));
    rst_ni = 1'b0;
    #1;
    check("rh_in_valid", PW'(fpu_in_valid_o), PW'(0));
    check("rh_busy_rst", PW'(busy_o), PW'(0));
    fpu_in_ready_i = 1'b1;
    #1;
    check("rh_req_ready", PW'(req_ready_o), PW'(0));
    tick();
    rst_ni = 1'b1;
    req_valid_i = '0;
    fpu_in_ready_i = 1'b0;
    #1;
    check("rh_busy_after", PW'(busy_o), PW'(0));
    tick();

    check("iss_q_drained", PW'(iss_q.size()), PW'(0));
    check("rsp_q_drained", PW'(rsp_q.size()), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
